// File: rtl/dir_button_conditioner_if.sv
// dir_button_conditioner_if: raw direction buttons in, clean move pulses and status out.
interface dir_button_conditioner_if;
   logic btn_n, btn_s, btn_e, btn_w;
   logic n, s, e, w, conflict, busy;
   modport master(output btn_n, btn_s, btn_e, btn_w, input n, s, e, w, conflict, busy);
   modport slave(input btn_n, btn_s, btn_e, btn_w, output n, s, e, w, conflict, busy);
endinterface

// File: rtl/dir_button_conditioner.sv
// dir_button_conditioner: synchronizes and debounces four direction buttons, emitting one pulse per unambiguous press.
module dir_button_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic clk,
   input logic reset,
   dir_button_conditioner_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;
   state_t state, state_d;
   logic [3:0] raw, db, dir, dir_d;
   logic conflict, conflict_d;
   assign raw = {bus.btn_n, bus.btn_s, bus.btn_e, bus.btn_w};
   for (genvar i = 0; i < 4; i++) begin : g_btn
      logic [SYNC_STAGES-1:0] sq;
      logic [CW-1:0] cnt;
      logic db_r, sync_b;
      assign sync_b = sq[SYNC_STAGES-1];
      assign db[i] = db_r;
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            sq <= '0;
            cnt <= '0;
            db_r <= 1'b0;
         end else begin
            sq <= {sq[SYNC_STAGES-2:0], raw[i]};
            if (sync_b == db_r)
               cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               db_r <= sync_b;
               cnt <= '0;
            end else
               cnt <= cnt + CW'(1);
         end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         dir <= '0;
         conflict <= 1'b0;
      end else begin
         state <= state_d;
         dir <= dir_d;
         conflict <= conflict_d;
      end
   // Presses arriving outside IDLE are dropped; HOLD waits for every button to clear.
   always_comb
      state_d = (state == IDLE) ? ((db == 4'b0) ? IDLE : ($onehot(db) ? PULSE : HOLD)) :
                (state == PULSE) ? HOLD : ((db == 4'b0) ? IDLE : HOLD);
   always_comb begin
      dir_d = (state == IDLE && $onehot(db)) ? db : 4'b0;
      conflict_d = (state == IDLE) && !$onehot0(db);
   end
   assign {bus.n, bus.s, bus.e, bus.w} = dir;
   assign bus.conflict = conflict;
   assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_dir_button_conditioner.sv
// tb_dir_button_conditioner: directed scenarios plus random presses against a behavioural model.
module tb_dir_button_conditioner;
   localparam int SS = 2, DC = 4;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   dir_button_conditioner_if bus();
   dir_button_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));
   int tests = 0, fails = 0;
   int pc[4];
   int cc, idx, first_at;
   logic [3:0] seq[$];
   logic [3:0] rq[$];
   logic [3:0] mdb;
   int run[4];
   bit idle, fresh;
   logic [5:0] mexp;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [5:0] outs();
      return {bus.n, bus.s, bus.e, bus.w, bus.conflict, bus.busy};
   endfunction
   task automatic model_reset();
      rq.delete();
      repeat (SS) rq.push_back(4'b0);
      mdb = 4'b0;
      foreach (run[i]) run[i] = 0;
      idle = 1'b1;
      fresh = 1'b0;
      mexp = '0;
   endtask
   task automatic model_step(input logic [3:0] raw);
      logic [3:0] seen, dir;
      int k;
      bit conf;
      seen = rq[0];
      k = $countones(mdb);
      dir = 4'b0;
      conf = 1'b0;
      if (idle) begin
         if (k == 1) dir = mdb;
         conf = (k >= 2);
         idle = (k == 0);
         fresh = (k == 1);
      end else begin
         if (!fresh && mdb == 4'b0) idle = 1'b1;
         fresh = 1'b0;
      end
      // A level is accepted once it has differed from the accepted level for DC edges in a row.
      for (int i = 0; i < 4; i++) begin
         if (seen[i] !== mdb[i]) begin
            run[i]++;
            if (run[i] == DC) begin
               mdb[i] = seen[i];
               run[i] = 0;
            end
         end else run[i] = 0;
      end
      rq.push_back(raw);
      void'(rq.pop_front());
      mexp = {dir, conf, !idle};
   endtask
   task automatic clear_counts();
      foreach (pc[i]) pc[i] = 0;
      cc = 0;
      idx = 0;
      first_at = -1;
      seq.delete();
   endtask
   task automatic cyc(input logic [3:0] raw, input string tag);
      logic [5:0] o;
      {bus.btn_n, bus.btn_s, bus.btn_e, bus.btn_w} = raw;
      if (!reset) model_step(raw);
      @(posedge clk);
      @(negedge clk);
      o = outs();
      check(tag, 32'(o), 32'(mexp));
      idx++;
      for (int i = 0; i < 4; i++) pc[i] += int'(o[5-i]);
      cc += int'(o[1]);
      if (o[5:2] != 4'b0) begin
         seq.push_back(o[5:2]);
         if (first_at < 0) first_at = idx;
      end
   endtask
   task automatic rst_pulse(input int n);
      #2 reset = 1'b1;
      #1 check("reset_async", 32'(outs()), 32'h0);
      model_reset();
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      logic [3:0] mask, raw;
      {bus.btn_n, bus.btn_s, bus.btn_e, bus.btn_w} = 4'b0;
      model_reset();
      clear_counts();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", 32'(outs()), 32'h0);
      reset = 1'b0;
      repeat (10) cyc(4'b0000, "idle");
      clear_counts();
      repeat (20) cyc(4'b0010, "east_hold");
      check("east_pulse_edge", 32'(first_at), 32'd7);
      check("east_count", 32'(pc[2]), 32'd1);
      check("east_others", 32'(pc[0] + pc[1] + pc[3]), 32'd0);
      repeat (6) cyc(4'b0000, "east_release");
      check("busy_before_7", 32'(bus.busy), 32'd1);
      cyc(4'b0000, "east_release");
      check("busy_after_7", 32'(bus.busy), 32'd0);
      clear_counts();
      repeat (3) cyc(4'b0100, "bounce");
      cyc(4'b0000, "bounce");
      repeat (2) cyc(4'b0100, "bounce");
      repeat (12) cyc(4'b0000, "bounce");
      check("bounce_pulses", 32'(pc[0] + pc[1] + pc[2] + pc[3] + cc), 32'd0);
      clear_counts();
      repeat (10) cyc(4'b1001, "nw_conflict");
      check("conflict_count", 32'(cc), 32'd1);
      check("conflict_no_dir", 32'(seq.size()), 32'd0);
      repeat (8) cyc(4'b0000, "nw_release");
      repeat (10) cyc(4'b0001, "w_alone");
      repeat (10) cyc(4'b0000, "w_release");
      check("w_after_conflict", 32'(pc[3]), 32'd1);
      clear_counts();
      repeat (3) cyc(4'b0010, "e_then_s");
      repeat (15) cyc(4'b0110, "e_then_s");
      repeat (10) cyc(4'b0000, "es_release");
      check("es_only_e", 32'({pc[1], pc[2]}), 32'({32'd0, 32'd1}));
      repeat (10) cyc(4'b0100, "s_alone");
      repeat (10) cyc(4'b0000, "s_release");
      check("s_after", 32'(pc[1]), 32'd1);
      clear_counts();
      repeat (4) cyc(4'b1000, "n_pre_reset");
      rst_pulse(2);
      clear_counts();
      repeat (12) cyc(4'b1000, "n_after_reset");
      check("n_reset_edge", 32'(first_at), 32'd7);
      check("n_reset_count", 32'(pc[0]), 32'd1);
      repeat (10) cyc(4'b0000, "n_release");
      clear_counts();
      foreach (pc[i]) begin
         mask = (i == 1) ? 4'b0100 : 4'b0010;
         if (i < 3) begin
            repeat (5) cyc(mask, "game_press");
            repeat (7) cyc(4'b0000, "game_gap");
         end
      end
      check("game_moves", 32'(seq.size()), 32'd3);
      if (seq.size() == 3) check("game_order", 32'({seq[0], seq[1], seq[2]}), 32'h242);
      for (int ep = 0; ep < 60; ep++) begin
         mask = ($urandom_range(0, 7) < 5) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(1, 15));
         repeat ($urandom_range(1, 12)) begin
            raw = mask;
            if ($urandom_range(0, 9) == 0) raw ^= 4'(1 << $urandom_range(0, 3));
            cyc(raw, "random");
         end
         repeat ($urandom_range(0, 10)) cyc(4'b0000, "random_gap");
         if ($urandom_range(0, 14) == 0) rst_pulse(1);
      end
      repeat (12) cyc(4'b0000, "drain");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
